// File: rtl/axis_checker.sv
// axis_checker: stream sink that generates its own back-pressure and checks
// that accepted data is a +1 incrementing sequence (modulo 2^WIDTH).
// Reports lock status, a saturating error count and a wrapping transfer count.
//
// Handshake: a transfer happens on a rising edge of clock where
// ivalid && iready. iready is registered and never depends on ivalid.
module axis_checker #(
    parameter int          WIDTH       = 8,
    parameter int          READY_MODE  = 0,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          LOCK_COUNT  = 4,
    parameter int          ERROR_WIDTH = 16,
    parameter int          COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       idata,
    input  logic                   ivalid,
    output logic                   iready,
    output logic                   locked,
    output logic [ERROR_WIDTH-1:0] errors,
    output logic [COUNT_WIDTH-1:0] transfers
);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam logic [7:0]  LOCK_RUN  = 8'(LOCK_COUNT);

    state_t                 state_q, state_d;
    logic [7:0]             run_q, run_d;
    logic [WIDTH-1:0]       expected_q, expected_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic                   iready_q, iready_d;
    logic                   locked_q, locked_d;
    logic [ERROR_WIDTH-1:0] errors_q, errors_d;
    logic [COUNT_WIDTH-1:0] transfers_q, transfers_d;

    logic                   xfer;
    logic                   match;
    logic [7:0]             run_new;

    assign xfer  = ivalid && iready_q;
    assign match = (idata == expected_q);

    // State register and all other flops; synchronous reset loads reset values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= SEARCH;
            run_q       <= 8'd0;
            expected_q  <= '0;
            lfsr_q      <= SEED;
            iready_q    <= 1'b0;
            locked_q    <= 1'b0;
            errors_q    <= '0;
            transfers_q <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            expected_q  <= expected_d;
            lfsr_q      <= lfsr_d;
            iready_q    <= iready_d;
            locked_q    <= locked_d;
            errors_q    <= errors_d;
            transfers_q <= transfers_d;
        end
    end

    // Next-state logic: run length tracking and SEARCH/LOCKED transitions.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        run_new = 8'd1;
        if (run_q != 8'd0 && match) begin
            run_new = run_q + 8'd1;
        end
        if (xfer) begin
            case (state_q)
                SEARCH: begin
                    if (run_new == LOCK_RUN) begin
                        state_d = LOCKED;
                        run_d   = 8'd0;
                    end else begin
                        run_d   = run_new;
                    end
                end
                LOCKED: begin
                    // A mismatch seeds the next search: expected is reloaded
                    // from the offending value on this same transfer.
                    if (!match) begin
                        state_d = SEARCH;
                        run_d   = 8'd1;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    run_d   = 8'd0;
                end
            endcase
        end
    end

    // Output and datapath logic: ready pattern, lock flag, counters, expected.
    always_comb begin
        lfsr_d      = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
        iready_d    = (READY_MODE == 1) ? lfsr_d[0] : 1'b1;
        locked_d    = (state_d == LOCKED);
        expected_d  = expected_q;
        errors_d    = errors_q;
        transfers_d = transfers_q;
        if (xfer) begin
            expected_d  = idata + {{(WIDTH-1){1'b0}}, 1'b1};
            transfers_d = transfers_q + COUNT_WIDTH'(1);
            if (state_q == LOCKED && !match && errors_q != {ERROR_WIDTH{1'b1}}) begin
                errors_d = errors_q + ERROR_WIDTH'(1);
            end
        end
    end

    assign iready    = iready_q;
    assign locked    = locked_q;
    assign errors    = errors_q;
    assign transfers = transfers_q;

endmodule

// File: tb/tb_axis_checker.sv
// Directed testbench for axis_checker. Three instances:
//   dut0: READY_MODE 0, defaults        (lock, wrap, errors, reset mid-lock)
//   dut1: READY_MODE 1, SEED 16'hACE1   (ready pattern, counter source)
//   dut2: READY_MODE 0, ERROR_WIDTH 2   (error saturation)
module tb_axis_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // dut0 signals
  logic        rst0 = 1'b1;
  logic [7:0]  idata0 = 8'h00;
  logic        ivalid0 = 1'b0;
  logic        iready0, locked0;
  logic [15:0] errors0;
  logic [31:0] transfers0;

  // dut1 signals
  logic        rst1 = 1'b1;
  logic [7:0]  idata1 = 8'h00;
  logic        ivalid1 = 1'b0;
  logic        iready1, locked1;
  logic [15:0] errors1;
  logic [31:0] transfers1;

  // dut2 signals
  logic        rst2 = 1'b1;
  logic [7:0]  idata2 = 8'h00;
  logic        ivalid2 = 1'b0;
  logic        iready2, locked2;
  logic [1:0]  errors2;
  logic [31:0] transfers2;

  axis_checker #(.WIDTH(8), .READY_MODE(0)) dut0 (
    .clock(clk), .reset(rst0), .idata(idata0), .ivalid(ivalid0),
    .iready(iready0), .locked(locked0), .errors(errors0), .transfers(transfers0)
  );

  axis_checker #(.WIDTH(8), .READY_MODE(1), .SEED(16'hACE1)) dut1 (
    .clock(clk), .reset(rst1), .idata(idata1), .ivalid(ivalid1),
    .iready(iready1), .locked(locked1), .errors(errors1), .transfers(transfers1)
  );

  axis_checker #(.WIDTH(8), .READY_MODE(0), .ERROR_WIDTH(2)) dut2 (
    .clock(clk), .reset(rst2), .idata(idata2), .ivalid(ivalid2),
    .iready(iready2), .locked(locked2), .errors(errors2), .transfers(transfers2)
  );

  // Golden ready model for dut1. Galois LFSR with mask 16'hB400; mask bit 0
  // is zero, so bit 0 of the next value is simply bit 1 of the current one.
  logic [15:0] lfsr_m;
  logic        exp_rdy;
  always @(posedge clk) begin
    if (rst1) begin
      lfsr_m  <= 16'hACE1;
      exp_rdy <= 1'b0;
    end else begin
      lfsr_m  <= (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
      exp_rdy <= lfsr_m[1];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat to dut0, hold until accepted, then drop ivalid.
  task automatic send0(input logic [7:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    idata0  = d;
    ivalid0 = 1'b1;
    while (!iready0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("send0_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    ivalid0 = 1'b0;
  endtask

  task automatic send2(input logic [7:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    idata2  = d;
    ivalid2 = 1'b1;
    while (!iready2 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("send2_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    ivalid2 = 1'b0;
  endtask

  // One-cycle reset pulse on dut0, then release.
  task automatic reset0();
    @(negedge clk);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst0 = 1'b0;
  endtask

  initial begin
    int xfers;
    logic rdy_now;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_iready", {31'd0, iready0}, 32'd0);
    check("rst_locked", {31'd0, locked0}, 32'd0);
    check("rst_errors", {16'd0, errors0}, 32'd0);
    check("rst_transfers", transfers0, 32'd0);
    @(negedge clk);
    rst0 = 1'b0;
    rst2 = 1'b0;
    @(posedge clk);
    #1;
    check("iready_after_reset", {31'd0, iready0}, 32'd1);

    // ---------------- basic lock: 0,1,2,3 ----------------
    send0(8'd0);
    send0(8'd1);
    send0(8'd2);
    check("not_locked_after_2", {31'd0, locked0}, 32'd0);
    send0(8'd3);
    check("locked_after_3", {31'd0, locked0}, 32'd1);
    check("transfers_4", transfers0, 32'd4);
    check("errors_0", {16'd0, errors0}, 32'd0);

    // ---------------- wrap-around ----------------
    reset0();
    send0(8'hFC);
    send0(8'hFD);
    send0(8'hFE);
    check("wrap_not_locked_FE", {31'd0, locked0}, 32'd0);
    send0(8'hFF);
    check("wrap_locked_FF", {31'd0, locked0}, 32'd1);
    send0(8'h00);
    check("wrap_locked_00", {31'd0, locked0}, 32'd1);
    check("wrap_errors_00", {16'd0, errors0}, 32'd0);
    for (int i = 1; i <= 5; i++) send0(8'(i));
    check("wrap_locked_05", {31'd0, locked0}, 32'd1);
    check("wrap_transfers", transfers0, 32'd10);

    // ---------------- errors in SEARCH ----------------
    reset0();
    send0(8'd5);
    send0(8'd9);
    send0(8'd2);
    send0(8'd7);
    check("search_locked", {31'd0, locked0}, 32'd0);
    check("search_errors", {16'd0, errors0}, 32'd0);
    check("search_transfers", transfers0, 32'd4);

    // ---------------- error injection ----------------
    reset0();
    for (int i = 0; i <= 9; i++) send0(8'(i));
    check("inj_locked_9", {31'd0, locked0}, 32'd1);
    send0(8'h20);
    check("inj_errors_20", {16'd0, errors0}, 32'd1);
    check("inj_locked_20", {31'd0, locked0}, 32'd0);
    send0(8'h21);
    send0(8'h22);
    check("inj_locked_22", {31'd0, locked0}, 32'd0);
    send0(8'h23);
    check("inj_locked_23", {31'd0, locked0}, 32'd1);
    check("inj_errors_23", {16'd0, errors0}, 32'd1);

    // ---------------- reset mid-lock (beat presented during reset) -------
    @(negedge clk);
    rst0    = 1'b1;
    idata0  = 8'h24;
    ivalid0 = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_locked", {31'd0, locked0}, 32'd0);
    check("midrst_errors", {16'd0, errors0}, 32'd0);
    check("midrst_transfers", transfers0, 32'd0);
    check("midrst_iready", {31'd0, iready0}, 32'd0);
    ivalid0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b0;
    send0(8'h24);
    send0(8'h25);
    send0(8'h26);
    check("relock_not_yet", {31'd0, locked0}, 32'd0);
    send0(8'h27);
    check("relock_locked", {31'd0, locked0}, 32'd1);
    check("relock_transfers", transfers0, 32'd4);

    // ---------------- saturation on dut2 (ERROR_WIDTH 2) ----------------
    for (int i = 0; i < 4; i++) send2(8'(i));
    check("sat_locked_0", {31'd0, locked2}, 32'd1);
    for (int blk = 1; blk <= 4; blk++) begin
      // Mismatch, then three more in-sequence values relock (run 1..4).
      send2(8'(blk * 16'h40 + 16'h05));
      check("sat_unlocked", {31'd0, locked2}, 32'd0);
      check("sat_errors", {30'd0, errors2}, (blk < 3) ? 32'(blk) : 32'd3);
      for (int k = 1; k <= 3; k++) send2(8'(blk * 16'h40 + 16'h05 + k));
      check("sat_relocked", {31'd0, locked2}, 32'd1);
    end
    check("sat_errors_final", {30'd0, errors2}, 32'd3);

    // ---------------- READY_MODE 1 with counter source ----------------
    @(negedge clk);
    rst1 = 1'b0;
    idata1  = 8'h00;
    ivalid1 = 1'b1;
    xfers   = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      check("lfsr_ready", {31'd0, iready1}, {31'd0, exp_rdy});
      rdy_now = iready1;
      @(posedge clk);
      #1;
      if (rdy_now) begin
        xfers++;
        idata1 = idata1 + 8'd1;
      end
    end
    ivalid1 = 1'b0;
    @(negedge clk);
    check("lfsr_transfers", transfers1, 32'(xfers));
    check("lfsr_locked", {31'd0, locked1}, 32'd1);
    check("lfsr_errors", {16'd0, errors1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_checker.md
Name: axis_checker

Overview:
Stream sink and checker. It consumes an axis stream produced by axis_counter, optionally after axis_pipe, axis_fifo or axis_throttle stages. It checks that the accepted data forms a +1 incrementing sequence, modulo 2^WIDTH. It generates its own back-pressure on iready, either always ready or pseudo-random, and reports lock status, an error count and a transfer count for on-board self-test of pipelines.

Parameters:
WIDTH, 8, data width of idata.
READY_MODE, 0, 0 = iready high every cycle after reset; 1 = iready driven by an LFSR pattern.
SEED, 16'hACE1, LFSR reset value; must be non-zero.
LOCK_COUNT, 4, consecutive in-sequence values needed to enter LOCKED; range 2..255.
ERROR_WIDTH, 16, width of the errors counter.
COUNT_WIDTH, 32, width of the transfers counter.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
idata  input  WIDTH  stream data
ivalid  input  1  stream valid
iready  output  1  stream ready (registered)
locked  output  1  high while in LOCKED state (registered)
errors  output  ERROR_WIDTH  sequence mismatches seen while LOCKED; saturating
transfers  output  COUNT_WIDTH  number of accepted transfers; wraps

Behaviour:
- Interface: one clock, `clock`; reset, `reset`, is synchronous and active-high. Every register is cleared or loaded on the rising edge of `clock` while `reset` = 1.
- Transfer: xfer = ivalid && iready, sampled on the rising edge. Only xfer cycles affect the checker state.
- Reset values:
  - iready = 0, locked = 0, errors = 0, transfers = 0.
  - Internal: state = SEARCH, run = 0, expected = 0, lfsr = SEED.
- iready generation:
  - Registered; first possible high is the cycle after reset deasserts.
  - READY_MODE 0: iready <= 1 every non-reset cycle.
  - READY_MODE 1: 16-bit Galois LFSR, polynomial mask 16'hB400. Each non-reset cycle: lfsr <= next, where next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0). In the same cycle iready <= next[0].
  - The LFSR advances every cycle regardless of ivalid.
- expected: on every xfer, expected <= idata + 1, truncated to WIDTH bits, so 0xFF is followed by 0x00 for WIDTH = 8. A match is idata == expected.
- transfers: += 1 on every xfer; wraps to 0 at all-ones.
- State machine, 2 states:
  - SEARCH, on xfer:
    - If run == 0: run <= 1.
    - Else if match: run <= run + 1.
    - Else: run <= 1.
    - If the new run == LOCK_COUNT: state <= LOCKED and run <= 0.
    - errors is never incremented in SEARCH.
  - LOCKED, on xfer:
    - On match: stay in LOCKED.
    - On mismatch: errors <= errors + 1, saturating at all-ones; state <= SEARCH; run <= 1. The mismatching value seeds the new search, because expected is already loaded from it.
- locked <= (next state == LOCKED). It rises one cycle after the xfer that completes LOCK_COUNT. It falls one cycle after the mismatching xfer.
- ivalid low or iready low: no state change except the LFSR and iready update.
- idata is ignored while ivalid = 0. The checker does not require ivalid to stay high once asserted.
- Reset mid-stream: all state returns to reset values on the next edge. Any transfer presented in the reset cycle is not counted, since iready is 0.
- Simultaneous match and counter wrap: no special case; the modular compare handles it.

Test Plan:
- READY_MODE 0, source sends 0,1,2,3,... with ivalid held high:
  - iready = 1 from the first cycle after reset.
  - locked = 1 in the cycle after the transfer of value 3.
  - transfers = 4 at that point; errors = 0.
- Wrap-around, WIDTH = 8, sequence 0xFC..0xFF, 0x00..0x05:
  - locked after 0xFF.
  - Stays locked through 0x00; errors = 0.
- Error injection, sequence 0..9, 0x20, 0x21, 0x22, 0x23:
  - After 0x20: errors = 1 and locked = 0.
  - After 0x23: locked = 1 again; errors remains 1.
- Errors in SEARCH: send 5, 9, 2, 7 from reset → locked = 0, errors = 0, transfers = 4.
- READY_MODE 1, SEED = 16'hACE1, ivalid held high:
  - The iready sequence matches a golden LFSR model bit for bit.
  - transfers equals the number of iready-high cycles.
  - With the counter source behind an axis_fifo, locked = 1 and errors = 0 after 1000 cycles.
- Reset mid-lock: assert reset for 1 cycle while locked with errors = 1 → next cycle locked = 0, errors = 0, transfers = 0, iready = 0. The stream then relocks after LOCK_COUNT transfers.
- Saturation: ERROR_WIDTH = 2, forced mismatches after each relock → errors stops at 3.
